// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer slice.
// Contents:
//   DEF_WIDTH / DEF_AMT_W : default operand width and shift-amount width
//   state_e               : sequencer FSM states (IDLE, SHIFT, DONE)
//   mode_e                : shift mode encoding (SHL = logical left, ROL = rotate left)
package shift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    SHL = 1'b0,
    ROL = 1'b1
  } mode_e;

endpackage : shift_pkg

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the CPU control unit and the shift sequencer.
// Signals:
//   start, operand, amount, rotate : request side, driven by the control unit
//   busy, done, result, carry, zero : status side, driven by the sequencer
// Modports:
//   master : control-unit view (drives the request)
//   slave  : sequencer view (drives the status)
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);

  logic             start;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             rotate;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output start, operand, amount, rotate,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, operand, amount, rotate,
    output busy, done, result, carry, zero
  );

endinterface : shift_sequencer_if

// File: rtl/shift_left_1.sv
// Combinational one-bit left shifter used as the sequencer's datapath step.
// Ports:
//   data    in  WIDTH  value to shift
//   rotate  in  1      0 = zero fill into bit 0, 1 = old MSB wraps into bit 0
//   shifted out WIDTH  data shifted left by one position
//   out_bit out 1      bit moved out of position WIDTH-1
module shift_left_1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             rotate,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  assign out_bit = data[WIDTH-1];
  assign shifted = {data[WIDTH-2:0], (rotate & data[WIDTH-1])};

endmodule : shift_left_1

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: shifts an operand left by 'amount'
// single-bit steps through a one-bit shifter, with start/done handshake and
// carry/zero status flags.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  shift_sequencer_if.slave: start/operand/amount/rotate in,
//        busy/done/result/carry/zero out
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  mode_e            mode_q,  mode_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] step_data;
  logic             step_out_bit;

  shift_left_1 #(
    .WIDTH (WIDTH)
  ) u_shift_left_1 (
    .data    (work_q),
    .rotate  (mode_q == ROL),
    .shifted (step_data),
    .out_bit (step_out_bit)
  );

  // Next-state, datapath and registered-status computation.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.operand;
          cnt_d   = bus.amount;
          mode_d  = bus.rotate ? ROL : SHL;
          carry_d = 1'b0;
          // A zero amount skips SHIFT and reports the operand unchanged.
          state_d = (bus.amount != CNT_ZERO) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = step_data;
        carry_d = step_out_bit;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        // Always pass through IDLE so start is never accepted back-to-back.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      carry_q <= 1'b0;
      mode_q  <= SHL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.result = work_q;
  assign bus.carry  = carry_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.zero   = (work_q == {WIDTH{1'b0}});

endmodule : shift_sequencer
